btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters.
- Serves the pipelined RISC-V core: combinational lookup at IF on the fetch PC; update and misprediction detection at EX.
- Generalises the fixed BTB with configurable depth, PC width and counter width, tag checking, an allocate-on-taken policy and performance counters.

Parameters:
- ENTRIES, 16, number of entries; power of two, at least 2; IDX_W = log2(ENTRIES).
- PC_W, 32, PC width in bits; PC_W must be greater than IDX_W+2.
- CNT_W, 2, direction counter width; at least 1.
- PERF_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  pipeline stall (DCACHE_stall | ICACHE_stall); freezes all state.
- if_pc  in  PC_W  fetch PC for lookup.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  predicted taken.
- pred_target  out  PC_W  predicted target; 0 when not hit.
- ex_valid  in  1  EX-stage instruction valid (not bubble/flushed).
- ex_is_branch  in  1  EX instruction is a branch/jump.
- ex_pc  in  PC_W  PC of the EX instruction.
- ex_taken  in  1  resolved direction.
- ex_target  in  PC_W  resolved target.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  PC_W  predicted target carried down the pipe.
- flush  out  1  mispredict; squash IF/ID.
- redirect_pc  out  PC_W  correct next PC on flush.
- perf_branches  out  PERF_W  resolved-branch count.
- perf_mispred  out  PERF_W  mispredict count.

Behaviour:
- Fields:
  - index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
  - Entry = {valid, tag, target[PC_W-1:0], cnt[CNT_W-1:0]}.
- Lookup (combinational, 0 latency):
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & cnt[MSB].
  - pred_target = entry target if pred_hit, else 0.
- Resolution (combinational):
  - res = ex_valid & ex_is_branch.
  - mispredict = res & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
  - flush = mispredict; flush is driven even while stall=1.
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4, modulo 2^PC_W (wraps).
  - redirect_pc = 0 when flush=0.
- Update: registered on the clk edge when res & !stall.
  - Hit at ex_pc: cnt saturating +1 if taken, -1 if not; saturates at all-ones and 0. If taken, target <= ex_target.
  - Miss and taken: allocate/overwrite the entry. valid=1, tag, target=ex_target, cnt = weakly taken (MSB=1, rest 0; for CNT_W=1, 1).
  - Miss and not taken: no change.
- Same index looked up and updated in one cycle: lookup returns pre-update contents; no bypass.
- Perf counters, on res & !stall:
  - perf_branches +1.
  - perf_mispred +1 if mispredict.
  - Both wrap modulo 2^PERF_W.
- stall=1: table and perf counters hold; outputs still reflect current inputs and state.
- Reset (rst=1 at edge):
  - All valid cleared; cnt set to weakly not-taken (MSB=0, rest 1; for CNT_W=1, 0); targets and tags 0; perf counters 0.
  - Reset overrides any same-cycle update. Mid-operation reset discards all learned state.
- After reset, all lookups miss: pred_hit=0, pred_taken=0, pred_target=0.

Decomposition:
- Shared package btb_pkg:
  - Localparams IDX_W and TAG_W derivation functions.
  - Counter encodings (weak taken / weak not-taken) as functions of CNT_W.
  - Entry struct typedef.
- Sub-module sat_counter: CNT_W-wide saturating up/down next-value logic, instantiated for the update path.

Test Plan:
- Reset then lookup: rst=1 for 2 cycles, if_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0, perf_branches=0.
- Allocate on taken: resolve ex_pc=0x40, ex_taken=1, ex_target=0x80, ex_pred_taken=0 -> same cycle flush=1, redirect_pc=0x80. Next cycle lookup 0x40 -> hit, taken, target 0x80; perf_mispred=1.
- Saturation: 3 more taken resolutions of 0x40 -> cnt=3. Then 2 not-taken -> cnt=1, pred_taken=0. The first not-taken gives flush=1, redirect_pc=0x44.
- Tag alias (ENTRIES=16): allocate 0x40→0x80, then lookup 0x440 -> pred_hit=0. Taken resolve of 0x440→0x100 overwrites; lookup 0x40 -> miss.
- Target mispredict: ex_taken=1, ex_pred_taken=1, ex_pred_target=0x80, ex_target=0x90 -> flush=1, redirect_pc=0x90; entry target becomes 0x90.
- Stall/edge: stall=1 during a resolution -> flush still 1, table and perf unchanged. Resolve ex_pc=0xFFFFFFFC not-taken mispredicted -> redirect_pc=0x00000000. rst asserted with a concurrent update -> table cleared.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared sizing helpers and direction-counter encodings for the branch target buffer.
package btb_pkg;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int pc_w, input int entries);
    return pc_w - $clog2(entries) - 2;
  endfunction

  // Weakly taken: MSB set, remaining bits clear.
  function automatic int weak_taken(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

  // Weakly not-taken: MSB clear, remaining bits set.
  function automatic int weak_not_taken(input int cnt_w);
    return (cnt_w == 1) ? 0 : (1 << (cnt_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// Saturating up/down next-value logic for one direction counter.
// Purely combinational; no handshake, the caller decides when to commit the value.
module sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             up,
  output logic [CNT_W-1:0] cnt_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_comb begin
    cnt_nxt = cnt;
    if (up) begin
      if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
    end else begin
      if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB: zero-latency IF lookup, same-cycle EX mispredict/redirect, update on the next edge.
// No backpressure; stall freezes table and perf counters while outputs keep tracking inputs.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(PC_W, ENTRIES);
  localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(weak_not_taken(CNT_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t tbl [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  entry_t           if_e, ex_e;
  logic             ex_hit, res, mispredict;
  logic [CNT_W-1:0] cnt_nxt;
  logic             unused_if_lsb;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
  assign unused_if_lsb = ^if_pc[1:0];

  // Lookup reads the registered table, so a same-cycle update is not visible here.
  assign if_e        = tbl[if_idx];
  assign pred_hit    = if_e.valid && (if_e.tag == if_tag);
  assign pred_taken  = pred_hit && if_e.cnt[CNT_W-1];
  assign pred_target = pred_hit ? if_e.target : '0;

  assign ex_e   = tbl[ex_idx];
  assign ex_hit = ex_e.valid && (ex_e.tag == ex_tag);

  assign res        = ex_valid && ex_is_branch;
  assign mispredict = res && ((ex_taken != ex_pred_taken) ||
                              (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  assign flush       = mispredict;
  assign redirect_pc = !mispredict ? '0 :
                       ex_taken    ? ex_target : ex_pc + PC_W'(4);

  sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
    .cnt     (ex_e.cnt),
    .up      (ex_taken),
    .cnt_nxt (cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WEAK_NT};
      end
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (res && !stall) begin
      perf_branches <= perf_branches + PERF_W'(1);
      if (mispredict) perf_mispred <= perf_mispred + PERF_W'(1);
      if (ex_hit) begin
        tbl[ex_idx].cnt <= cnt_nxt;
        if (ex_taken) tbl[ex_idx].target <= ex_target;
      end else if (ex_taken) begin
        // Allocate on taken only; a not-taken miss leaves the slot's current owner alone.
        tbl[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: ex_target, cnt: WEAK_T};
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: stimulus queues expected outputs, a negedge monitor pops and compares them.
module tb_btb_predictor;

  localparam int K_HIT = 0, K_TAKEN = 1, K_TGT = 2, K_FLUSH = 3, K_REDIR = 4, K_PBR = 5, K_PMIS = 6;

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        flush;
  logic [31:0] redirect_pc, perf_branches, perf_mispred;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  btb_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .if_pc          (if_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .perf_branches  (perf_branches),
    .perf_mispred   (perf_mispred)
  );

  always #5 clk = ~clk;

  function automatic string kname(input logic [3:0] k);
    case (k)
      K_HIT:   return "pred_hit";
      K_TAKEN: return "pred_taken";
      K_TGT:   return "pred_target";
      K_FLUSH: return "flush";
      K_REDIR: return "redirect_pc";
      K_PBR:   return "perf_branches";
      default: return "perf_mispred";
    endcase
  endfunction

  function automatic logic [31:0] actual(input logic [3:0] k);
    case (k)
      K_HIT:   return {31'b0, pred_hit};
      K_TAKEN: return {31'b0, pred_taken};
      K_TGT:   return pred_target;
      K_FLUSH: return {31'b0, flush};
      K_REDIR: return redirect_pc;
      K_PBR:   return perf_branches;
      default: return perf_mispred;
    endcase
  endfunction

  // Monitor: outputs are combinational, so every expectation queued this cycle is due at the negedge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.kind);
      n_checks++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", kname(e.kind), $time, a, e.val);
      end
    end
  end

  task automatic expect_val(input int k, input logic [31:0] v);
    exp_t e;
    e.kind = 4'(k);
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    stall        = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
    if_pc = pc;
    expect_val(K_HIT, {31'b0, hit});
    expect_val(K_TAKEN, {31'b0, tk});
    expect_val(K_TGT, tgt);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic exp_fl, input logic [31:0] exp_rd);
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    expect_val(K_FLUSH, {31'b0, exp_fl});
    expect_val(K_REDIR, exp_rd);
  endtask

  task automatic perf(input logic [31:0] b, input logic [31:0] m);
    expect_val(K_PBR, b);
    expect_val(K_PMIS, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; if_pc = 32'h0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state: everything misses, counters zero, no flush.
    look(32'h40, 0, 0, 32'h0); perf(0, 0);
    expect_val(K_FLUSH, 0); expect_val(K_REDIR, 0);
    tick();

    // Allocate on taken; lookup in the same cycle still sees the old contents.
    resolve(32'h40, 1, 32'h80, 0, 32'h0, 1, 32'h80);
    look(32'h40, 0, 0, 32'h0);
    tick();
    look(32'h40, 1, 1, 32'h80); perf(1, 1);
    tick();

    // Three correct taken predictions: counter 2 -> 3 -> 3 -> 3.
    for (int i = 0; i < 3; i++) begin
      resolve(32'h40, 1, 32'h80, 1, 32'h80, 0, 32'h0);
      tick();
    end
    look(32'h40, 1, 1, 32'h80); perf(4, 1);
    tick();

    // Two not-taken outcomes, both predicted taken: 3 -> 2 -> 1.
    resolve(32'h40, 0, 32'h80, 1, 32'h80, 1, 32'h44);
    tick();
    look(32'h40, 1, 1, 32'h80);
    tick();
    resolve(32'h40, 0, 32'h80, 1, 32'h80, 1, 32'h44);
    tick();
    look(32'h40, 1, 0, 32'h80); perf(6, 3);
    tick();

    // Wrong target with correct direction: counter 1 -> 2, target replaced.
    resolve(32'h40, 1, 32'h90, 1, 32'h80, 1, 32'h90);
    tick();
    look(32'h40, 1, 1, 32'h90); perf(7, 4);
    tick();

    // Tag alias at the same index.
    look(32'h440, 0, 0, 32'h0);
    tick();
    resolve(32'h440, 1, 32'h100, 0, 32'h0, 1, 32'h100);
    tick();
    look(32'h40, 0, 0, 32'h0);
    tick();
    look(32'h440, 1, 1, 32'h100); perf(8, 5);
    tick();

    // Stalled resolution: flush still visible, state frozen.
    stall = 1'b1;
    resolve(32'h40, 1, 32'h200, 0, 32'h0, 1, 32'h200);
    tick();
    look(32'h40, 0, 0, 32'h0); perf(8, 5);
    tick();

    // Not a qualified branch: no flush, no count.
    resolve(32'h80, 1, 32'h300, 0, 32'h0, 0, 32'h0);
    ex_is_branch = 1'b0;
    tick();
    resolve(32'h80, 1, 32'h300, 0, 32'h0, 0, 32'h0);
    ex_valid = 1'b0;
    tick();
    perf(8, 5);
    tick();

    // Fall-through wraps; not-taken miss does not allocate.
    resolve(32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 1, 32'h0000_0000);
    tick();
    look(32'hFFFF_FFFC, 0, 0, 32'h0); perf(9, 6);
    tick();

    // Reset wins over a concurrent update.
    rst = 1'b1;
    resolve(32'h140, 1, 32'h300, 0, 32'h0, 1, 32'h300);
    tick();
    rst = 1'b0;
    look(32'h440, 0, 0, 32'h0); perf(0, 0);
    tick();
    look(32'h140, 0, 0, 32'h0);
    tick();

    @(posedge clk); #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
